// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer: adds operand pairs from two round-robin requesters
// using a single 5-bit slice adder. The slice adder is reused over SLICES
// cycles per operation, with the carry rippling through a carry register.
// Optional feature macro: ADDER_SLICE_SEQUENCER_SUB_EN adds the req0_sub and
// req1_sub inputs. With sub=1 the block computes a - b as a + ~b + 1.
module adder_slice_sequencer #(
  parameter  int SLICES = 4,
  localparam int W      = 5 * SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
`ifdef ADDER_SLICE_SEQUENCER_SUB_EN
  input  logic         req0_sub,
  input  logic         req1_sub,
`endif
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic         busy
);

  // The slice counter is at least one bit wide, even when SLICES is 1.
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          id_q, id_d;
  logic          sub_q, sub_d;
  // last_q is 1 when req1 was accepted last. That gives req0 the next contention.
  logic          last_q, last_d;

  logic          idle;
  logic          calc;
  logic          any_valid;
  logic          grant1;
  logic          sub_sel;

  logic [4:0]    a_sl [SLICES];
  logic [4:0]    b_sl [SLICES];
  logic [4:0]    a_cur;
  logic [4:0]    b_cur;
  logic [5:0]    slice_res;

  assign idle      = (state_q == IDLE);
  assign calc      = (state_q == CALC);
  assign any_valid = req0_valid | req1_valid;

  // Round-robin arbitration. A lone requester always wins. When both are
  // valid, the requester that was not accepted last wins.
  assign grant1 = (req0_valid & req1_valid) ? ~last_q : req1_valid;

  assign req0_ready = idle & req0_valid & ~grant1;
  assign req1_ready = idle & req1_valid &  grant1;

`ifdef ADDER_SLICE_SEQUENCER_SUB_EN
  assign sub_sel = grant1 ? req1_sub : req0_sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Split the registered operands into 5-bit slices. Merge the slice result
  // into the sum slice that the counter selects. All other sum slices keep
  // their values.
  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign a_sl[gi] = a_q[5*gi +: 5];
    assign b_sl[gi] = b_q[5*gi +: 5];
    assign sum_d[5*gi +: 5] = (calc && (cnt_q == CW'(gi))) ? slice_res[4:0]
                                                            : sum_q[5*gi +: 5];
  end

  // This is the only adder in the block. It computes one 5-bit slice plus the
  // carry register. For a subtraction, b is inverted one slice at a time.
  assign a_cur     = a_sl[cnt_q];
  assign b_cur     = b_sl[cnt_q] ^ {5{sub_q}};
  assign slice_res = {1'b0, a_cur} + {1'b0, b_cur} + {5'b0, carry_q};

  // Next-state logic for the sequencer, with operand capture on a handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    sub_d   = sub_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = CALC;
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          id_d    = grant1;
          sub_d   = sub_sel;
          // The carry-in is 0 for an add and 1 for a subtract, which completes
          // the two's complement of b.
          carry_d = sub_sel;
          cnt_d   = '0;
          last_d  = grant1;
        end
      end
      CALC: begin
        carry_d = slice_res[5];
        if (cnt_q == LAST_SLICE) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and arbitration registers, with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      id_q    <= 1'b0;
      sub_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      sub_q   <= sub_d;
      last_q  <= last_d;
    end
  end

  // The response outputs come straight from registers. They cannot change in
  // DONE until the consumer takes the result.
  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
  assign busy      = ~idle;

endmodule

// File: doc/adder_slice_sequencer.md
ADDER_SLICE_SEQUENCER -- requirements
Module: adder_slice_sequencer

Interface
REQ-001 Parameter SLICES, default 4: number of 5-bit slices; operand width W = 5*SLICES (20 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  requester has an operand pair pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester's pair accepted this cycle when valid&ready.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-007 rsp_valid  output  1  result available.
REQ-008 rsp_ready  input  1  consumer takes result when rsp_valid&rsp_ready.
REQ-009 rsp_sum  output  W  result; rsp_cout  output  1  carry out of MSB slice; rsp_id  output  1  index of the requester that issued the pair.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL contain exactly one 5-bit slice adder with carry-in, time-shared across slices and requesters; no W-bit adder is permitted.
REQ-012 FSM states SHALL be IDLE, CALC, DONE; transitions: IDLE->CALC on handshake, CALC->DONE after slice SLICES-1, DONE->IDLE on rsp handshake.
REQ-013 In IDLE, reqN_ready SHALL be combinationally high only for the granted requester; both ready low in CALC and DONE.
REQ-014 Grant: if one valid, grant it; if both valid, grant the requester not accepted last (round-robin); the last-accepted pointer SHALL update only on a handshake.
REQ-015 On handshake, operands, requester id and op SHALL be registered; slice counter cleared; carry register loaded with 0 (add).
REQ-016 In CALC, on each edge slice k (bits 5k+4:5k) SHALL be computed as a_k + b_k + carry; 5-bit result written into rsp_sum slice k; carry register takes the slice carry-out; k increments.
REQ-017 Latency: accept on edge T -> rsp_valid high in the cycle after edge T+SLICES; back-to-back throughput one result per SLICES+2 cycles minimum.
REQ-018 In DONE, rsp_valid, rsp_sum, rsp_cout, rsp_id SHALL hold stable until rsp_ready is sampled high; rsp_cout equals the final carry register.
REQ-019 Requests arriving while busy SHALL remain pending (ready low); none are dropped.
REQ-020 rsp_sum SHALL equal (a + b) mod 2^W and rsp_cout bit W of a + b, for all operand values including all-ones.
REQ-021 Slice counter SHALL be ceil(log2(SLICES)) bits wide minimum and never exceed SLICES-1.

Reset
REQ-022 On rst_n low, asynchronously: state IDLE, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, busy 0, carry 0, counter 0, last-accepted pointer = 1 (req0 wins first contention).
REQ-023 Reset asserted mid-CALC or mid-DONE SHALL abort the operation; no result is emitted after deassertion.
REQ-024 First handshake possible in the first cycle after rst_n deasserts.

Configuration
REQ-025 Macro ADDER_SLICE_SEQUENCER_SUB_EN: when defined, inputs req0_sub, req1_sub (1 bit each) SHALL exist; a registered sub=1 SHALL compute a - b by using ~b per slice and initial carry 1; rsp_cout = 1 means no borrow.
REQ-026 Without the macro, reqN_sub ports SHALL be absent and behaviour is add-only per REQ-015..020.

Verification
REQ-027 req0 a=0xFFFFF b=0x00001, rsp_ready=1 -> rsp_valid 4 cycles after accept edge, rsp_sum=0x00000, rsp_cout=1, rsp_id=0.
REQ-028 Both valid from reset, a0=0x12345 b0=0x11111, a1=0x0000F b1=0x00001 -> first result 0x23456 id 0, second 0x00010 id 1; then both valid again -> req0 granted.
REQ-029 rsp_ready held low 10 cycles in DONE with req1 valid -> rsp outputs stable, req1_ready low, busy 1; on release, req1 accepted next IDLE cycle.
REQ-030 rst_n pulsed low in 2nd CALC cycle -> all outputs 0 immediately, no rsp_valid afterwards until a new handshake.
REQ-031 (SUB_EN) a=0x00005 b=0x00007 sub=1 -> rsp_sum=0xFFFFE, rsp_cout=0; a=0x00007 b=0x00005 sub=1 -> 0x00002, rsp_cout=1.
REQ-032 Random 10k pairs, random valid/ready stalls -> every result matches W-bit reference sum, order and ids consistent with round-robin.
